alu_forward_ctrl: RTL and testbench
===================================

# alu_forward_ctrl

Sequential forwarding and load-use hazard controller for the 5-stage pipeline. It tracks destination-register metadata for the instructions in EX, MEM and WB, and drives the registered 2-bit select codes for the two 3-input ALU operand muxes in EX. It also raises a stall request when a load is followed directly by a dependent instruction. It sits between the ID-stage decoder and the EX-stage operand muxes; it carries no data, only register indices and control bits.

## Interface
- REG_ADDR_W, 5, register index width
- CNT_W, 32, width of the stall performance counter
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pipe_en  in  1  global advance enable; 0 freezes all internal state and outputs
- flush  in  1  branch/jump taken; the instruction currently in ID is killed
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  source register indices of the ID instruction
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1/rs2
- id_rd  in  REG_ADDR_W  destination register of the ID instruction
- id_reg_write  in  1  the ID instruction writes id_rd
- id_mem_read  in  1  the ID instruction is a load
- stall_out  out  1  hold PC and IF/ID, insert bubble into EX (combinational)
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects for the instruction in EX: 00 register-file value, 01 EX/MEM ALU result, 10 MEM/WB writeback value; 11 never driven
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Three slots: EX, MEM, WB. Each slot holds {valid, rd, reg_write, mem_read}.
- A slot "produces" register r when it is valid, has reg_write set, its rd equals r, and r != 0. Register x0 is never forwarded and never stalls.
- Load-use hazard:
  - load_use = id_valid & !flush & EX slot valid & EX.mem_read & EX.reg_write & EX.rd != 0
  - and at least one of: (id_use_rs1 & id_rs1 == EX.rd) or (id_use_rs2 & id_rs2 == EX.rd).
- stall_out = load_use & pipe_en.
- Select computation for each operand, evaluated for the ID instruction at the edge where it advances:
  - If the current EX slot produces the source, the select is 01. This is priority, since EX becomes MEM.
  - Else if the current MEM slot produces the source, the select is 10, since MEM becomes WB.
  - Else the select is 00.
  - An operand not used (id_use_* = 0) gets 00.
- At each rising edge with pipe_en = 1, in priority order:
  - rst: all slots invalid with fields zeroed, fwd_a_sel = fwd_b_sel = 00, stall_cnt = 0.
  - flush, or stall_out, or !id_valid: WB <= MEM, MEM <= EX, EX <= bubble (valid = 0), both selects <= 00.
  - Otherwise: WB <= MEM, MEM <= EX, EX <= ID fields, and the selects load the computed codes.
  - stall_cnt increments when stall_out = 1 and saturates at all-ones.
- pipe_en = 0: every register holds, including the selects and stall_cnt. stall_out is forced to 0.
- Flush has priority over stall. A killed ID instruction never causes a stall.
- The register file is write-before-read. A producer in WB while the consumer is in ID needs no forwarding; it gets select 00.

## Timing
- fwd_a_sel and fwd_b_sel are registered. They are valid for the whole cycle in which the consumer occupies EX, with zero combinational delay from the ID inputs.
- stall_out is combinational from the EX-slot registers and the ID inputs, and is valid in the same cycle as the ID instruction.
- A load-use hazard stalls for exactly 1 cycle. The next cycle the load is in MEM, load_use evaluates to 0, the consumer advances, and its select becomes 10.
- Latency from producer to consumer:
  - Back-to-back ALU ops give select 01, with no stall.
  - One intervening instruction gives select 10.
  - Two or more intervening instructions give select 00.
- A reset in mid-operation clears all slots on that edge. The first cycle after reset has stall_out = 0 and selects of 00.

## Test plan
- Back-to-back ALU dependency: add x5 followed by sub with rs1 = x5. The cycle after sub enters EX, fwd_a_sel = 01, fwd_b_sel = 00, and stall_out stays 0 throughout.
- Single-gap dependency: add x5, nop, then rs2 = x5. The consumer in EX sees fwd_b_sel = 10. With two nops between, fwd_b_sel = 00.
- Load-use: lw x7 followed by an op using rs2 = x7. stall_out = 1 for exactly one cycle, one bubble enters EX (selects 00), the consumer then sees fwd_b_sel = 10, and stall_cnt increments by 1.
- x0 and priority cases:
  - lw x0 followed by use of x0: no stall and selects 00.
  - add x3 in MEM and add x3 in EX with consumer rs1 = x3: fwd_a_sel = 01.
- Flush and hold:
  - flush = 1 during a load-use condition: stall_out = 0, EX becomes a bubble, and stall_cnt is unchanged.
  - pipe_en = 0 for 3 cycles mid-sequence: outputs and slots frozen, stall_out = 0, and the sequence resumes identically.
- Reset mid-stream: assert rst while a load-use stall is pending. On the next edge, selects = 00, stall_out = 0 and stall_cnt = 0.

Source files
------------

// File: rtl/alu_forward_ctrl.sv
// ============================================================================
// Module      : alu_forward_ctrl
// Description : Operand-forwarding select and load-use stall control for EX
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_en,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic                  stall_out,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [1:0] c_SEL_RF  = 2'b00;
    localparam logic [1:0] c_SEL_EXM = 2'b01;
    localparam logic [1:0] c_SEL_MWB = 2'b10;

    // Only EX needs mem_read; MEM and WB just track producers
    logic                  r_ex_valid, r_ex_reg_write, r_ex_mem_read;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_mem_valid, r_mem_reg_write;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_valid, r_wb_reg_write;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    logic [1:0]            r_fwd_a_sel, r_fwd_b_sel;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic                  w_ex_is_load, w_load_use, w_advance;
    logic [1:0]            w_sel_a, w_sel_b;

    function automatic logic produces(
        input logic                  v,
        input logic                  rw,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] r
    );
        return v & rw & (rd == r) & (r != '0);
    endfunction

    function automatic logic [1:0] select_for(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] r
    );
        if (!used)
            return c_SEL_RF;
        else if (produces(r_ex_valid, r_ex_reg_write, r_ex_rd, r))
            return c_SEL_EXM;
        else if (produces(r_mem_valid, r_mem_reg_write, r_mem_rd, r))
            return c_SEL_MWB;
        // A WB producer is already visible through the write-before-read file
        else if (produces(r_wb_valid, r_wb_reg_write, r_wb_rd, r))
            return c_SEL_RF;
        else
            return c_SEL_RF;
    endfunction

    assign w_ex_is_load = r_ex_valid & r_ex_mem_read & r_ex_reg_write & (r_ex_rd != '0);
    assign w_load_use   = id_valid & ~flush & w_ex_is_load &
                          ((id_use_rs1 & (id_rs1 == r_ex_rd)) |
                           (id_use_rs2 & (id_rs2 == r_ex_rd)));
    assign w_advance    = id_valid & ~flush & ~w_load_use;
    assign w_sel_a      = select_for(id_use_rs1, id_rs1);
    assign w_sel_b      = select_for(id_use_rs2, id_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid      <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_rd         <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_rd        <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_rd         <= '0;
            r_fwd_a_sel     <= c_SEL_RF;
            r_fwd_b_sel     <= c_SEL_RF;
            r_stall_cnt     <= '0;
        end else if (pipe_en) begin
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_rd         <= r_mem_rd;
            r_mem_valid     <= r_ex_valid;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_rd        <= r_ex_rd;
            if (w_advance) begin
                r_ex_valid     <= 1'b1;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
                r_ex_rd        <= id_rd;
                r_fwd_a_sel    <= w_sel_a;
                r_fwd_b_sel    <= w_sel_b;
            end else begin
                r_ex_valid     <= 1'b0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
                r_ex_rd        <= '0;
                r_fwd_a_sel    <= c_SEL_RF;
                r_fwd_b_sel    <= c_SEL_RF;
            end
            if (w_load_use && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_out = w_load_use & pipe_en;
    assign fwd_a_sel = r_fwd_a_sel;
    assign fwd_b_sel = r_fwd_b_sel;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_forward_ctrl.sv
// ============================================================================
// Module      : tb_alu_forward_ctrl
// Description : Scoreboard bench for alu_forward_ctrl select and stall codes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_forward_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    logic                  clk = 1'b0;
    logic                  rst, pipe_en, flush, id_valid;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
    logic                  id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic                  stall_out;
    logic [1:0]            fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0]      stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    alu_forward_ctrl #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall_out(stall_out), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One ID cycle: drive, check stall before the edge, check selects after it
    task automatic step(input string tag, input logic v, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic rw, input logic mr,
                        input logic fl, input logic en, input logic rs,
                        input logic es, input logic [1:0] ea, input logic [1:0] eb);
        logic [3:0] e;
        @(negedge clk);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
        flush = fl; pipe_en = en; rst = rs;
        #1;
        chk({tag, "_stall"}, {31'd0, stall_out}, {31'd0, es});
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sel_a"}, {30'd0, fwd_a_sel}, {30'd0, e[3:2]});
            chk({tag, "_sel_b"}, {30'd0, fwd_b_sel}, {30'd0, e[1:0]});
        end
    endtask

    initial begin
        rst = 1'b1; pipe_en = 1'b1; flush = 1'b0; id_valid = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel_a", {30'd0, fwd_a_sel}, 32'd0);
        chk("rst_sel_b", {30'd0, fwd_b_sel}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);

        //        tag        v  rd  rs1 rs2 u1 u2 rw mr fl en rs  st  a      b
        // back-to-back ALU
        step("add5",   1, 5,  1,  2,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("sub_b2b",1, 6,  5,  4,  1, 1, 1, 0, 0, 1, 0, 0, 2'b01, 2'b00);
        step("nop0",   0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        // one-gap and two-gap
        step("add5b",  1, 5,  1,  2,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("nop1",   0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("gap1",   1, 7,  1,  5,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b10);
        step("add5c",  1, 5,  1,  2,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("nop2",   0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("nop3",   0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("gap2",   1, 8,  1,  5,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        // load-use
        step("lw7",    1, 7,  2,  0,  1, 0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("lu_stall",1,9,  1,  7,  1, 1, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        chk("cnt_lu", stall_cnt, 32'd1);
        step("lu_go",  1, 9,  1,  7,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b10);
        chk("cnt_lu_hold", stall_cnt, 32'd1);
        // x0 never forwards or stalls; EX beats MEM; unused operand gets 00
        step("lw0",    1, 0,  1,  0,  1, 0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("use_x0", 1, 10, 0,  0,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("add3a",  1, 3,  1,  2,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("add3b",  1, 3,  1,  2,  1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        step("prio",   1, 11, 3,  3,  1, 0, 1, 0, 0, 1, 0, 0, 2'b01, 2'b00);
        // flush during load-use
        step("lw12",   1, 12, 1,  0,  1, 0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("flush",  1, 13, 12, 0,  1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        chk("cnt_flush", stall_cnt, 32'd1);
        step("post_fl",1, 13, 12, 11, 1, 1, 1, 0, 0, 1, 0, 0, 2'b10, 2'b00);
        // freeze with a pending load-use, then resume
        step("lw14",   1, 14, 13, 0,  1, 0, 1, 1, 0, 1, 0, 0, 2'b01, 2'b00);
        for (int i = 0; i < 3; i++)
            step("frz",  1, 15, 1,  14, 1, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00);
        chk("cnt_frz", stall_cnt, 32'd1);
        step("res_st", 1, 15, 1,  14, 1, 1, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        step("res_go", 1, 15, 1,  14, 1, 1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b10);
        chk("cnt_res", stall_cnt, 32'd2);
        // reset while a load-use stall is pending
        step("lw16",   1, 16, 1,  0,  1, 0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("rst_mid",1, 17, 16, 0,  1, 0, 1, 0, 0, 1, 1, 1, 2'b00, 2'b00);
        chk("cnt_rst", stall_cnt, 32'd0);
        step("post_rst",1,17, 16, 0,  1, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        chk("cnt_post_rst", stall_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
